// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester byte streams plus TX engine handshake seen by the scheduler
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic [IW-1:0]        grant_id;
  logic                 grant_active;
  logic                 timeout_err;
  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, grant_active, timeout_err
  );
  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_start, tx_data, grant_id, grant_active, timeout_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART TX byte engine across NUM_REQ message sources
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                clk,
  input logic                rst,
  uart_tx_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, GAP = 2'd3;
  localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);
  localparam logic [15:0] GAP_LAST  = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  logic [1:0]    r_state;
  logic [IW-1:0] r_gid;
  logic          r_active;
  logic          r_err;
  logic          r_last;
  logic [7:0]    r_data;
  logic [7:0]    r_burst;
  logic [15:0]   r_gap;
  logic [31:0]   r_to;
  logic          w_start;
  logic [7:0]    w_byte;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_idx;
  // descending scan so the nearest valid index after the last grantee wins
  always_comb begin
    w_pick = r_gid;
    w_idx  = r_gid;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_gid) + k) % NUM_REQ);
      w_pick = bus.req_valid[w_idx] ? w_idx : w_pick;
    end
  end
  assign w_start          = (r_state == SEND) && bus.req_valid[r_gid];
  assign w_byte           = bus.req_data[8*r_gid +: 8];
  assign bus.tx_start     = w_start;
  assign bus.tx_data      = w_start ? w_byte : r_data;
  assign bus.req_ready    = w_start ? (NUM_REQ'(1) << r_gid) : '0;
  assign bus.grant_id     = r_gid;
  assign bus.grant_active = r_active;
  assign bus.timeout_err  = r_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_gid    <= IW'(NUM_REQ - 1);
      r_active <= 1'b0;
      r_err    <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= 8'h00;
      r_burst  <= 8'd0;
      r_gap    <= 16'd0;
      r_to     <= 32'd0;
    end else
      case (r_state)
        IDLE:
          if (|bus.req_valid) begin
            r_gid    <= w_pick;
            r_active <= 1'b1;
            r_burst  <= 8'd0;
            r_state  <= SEND;
          end
        SEND:
          if (w_start) begin
            r_data  <= w_byte;
            r_last  <= bus.req_last[r_gid];
            r_burst <= (r_burst == BURST_MAX) ? r_burst : r_burst + 8'd1;
            r_to    <= 32'd0;
            r_state <= WAIT;
          end else begin
            r_active <= 1'b0;
            r_gap    <= 16'd0;
            r_state  <= GAP;
          end
        WAIT:
          if (bus.tx_done) begin
            if (r_last || r_burst == BURST_MAX) begin
              r_active <= 1'b0;
              r_gap    <= 16'd0;
              r_state  <= GAP;
            end else
              r_state <= SEND;
          end else if (r_to == TO_LAST) begin
            r_err    <= 1'b1;
            r_active <= 1'b0;
            r_gap    <= 16'd0;
            r_state  <= GAP;
          end else
            r_to <= r_to + 32'd1;
        default:
          if (r_gap >= GAP_LAST)
            r_state <= IDLE;
          else
            r_gap <= r_gap + 16'd1;
      endcase
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized message traffic checked against a transaction-level round-robin model
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int MB  = 8;
  localparam int GAP = 16;
  localparam int TO  = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();
  uart_tx_scheduler #(.NUM_REQ(N), .MAX_BURST(MB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rr = N - 1;
  logic [8:0] qb [N][64];
  int qh [N];
  int qt [N];
  int en;
  int e_id [512];
  logic [7:0] e_dat [512];
  int e_next [512];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic push_byte(input int r, input logic l, input logic [7:0] d);
    if (qh[r] == qt[r]) begin
      qh[r] = 0;
      qt[r] = 0;
    end
    qb[r][qt[r]] = {l, d};
    qt[r]++;
  endtask
  task automatic push_msg(input int r, input int len);
    for (int b = 0; b < len; b++) push_byte(r, b == len - 1, 8'($urandom));
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = qh[i] < qt[i];
      bus.req_data[8*i +: 8] = (qh[i] < qt[i]) ? qb[i][qh[i]][7:0] : 8'($urandom);
      bus.req_last[i]        = (qh[i] < qt[i]) ? qb[i][qh[i]][8] : 1'($urandom);
    end
  endtask
  task automatic consume();
    for (int i = 0; i < N; i++) if (bus.req_ready[i] && bus.req_valid[i]) qh[i]++;
  endtask
  // expected (requester, byte) order and the spacing from each done to the next start
  task automatic model();
    int h [N];
    int j, n;
    logic lst;
    en = 0;
    for (int i = 0; i < N; i++) h[i] = qh[i];
    while (1) begin
      j = -1;
      for (int k = N; k >= 1; k--) if (h[(rr + k) % N] < qt[(rr + k) % N]) j = (rr + k) % N;
      if (j < 0) break;
      n = 0;
      do begin
        e_id[en]   = j;
        e_dat[en]  = qb[j][h[j]][7:0];
        e_next[en] = 1;
        lst = qb[j][h[j]][8];
        h[j]++;
        n++;
        en++;
      end while (!lst && n < MB && h[j] < qt[j]);
      e_next[en-1] = (lst || n == MB) ? GAP + 2 : GAP + 3;
      rr = j;
    end
  endtask
  task automatic run_round();
    int idx, exp_c, done_at, lim;
    model();
    idx = 0;
    exp_c = cyc + 1;
    done_at = -1;
    lim = cyc + 6000;
    while ((idx < en || cyc <= done_at) && cyc < lim) begin
      drive();
      bus.tx_done = (cyc == done_at);
      @(negedge clk);
      if (bus.tx_start) begin
        if (idx < en) begin
          check("start_cyc", cyc, exp_c);
          check("grant_id", bus.grant_id, e_id[idx]);
          check("tx_data", bus.tx_data, e_dat[idx]);
          check("ready_onehot", bus.req_ready, 1 << e_id[idx]);
          check("active_send", bus.grant_active, 1);
        end else
          check("extra_start", idx, en - 1);
        done_at = cyc + int'($urandom_range(1, 6));
        if (idx < en) exp_c = done_at + e_next[idx];
        idx++;
      end else
        check("ready_quiet", bus.req_ready, 0);
      if (idx > 0 && idx <= en && cyc == done_at + 1 && e_next[idx-1] == GAP + 2)
        check("active_rel", bus.grant_active, 0);
      consume();
      tick();
    end
    bus.tx_done = 1'b0;
    check("start_count", idx, en);
  endtask
  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      bus.tx_done = 1'($urandom);
      @(negedge clk);
      check("idle_start", bus.tx_start, 0);
      tick();
    end
    bus.tx_done = 1'b0;
    check("idle_active", bus.grant_active, 0);
    check("idle_gid", bus.grant_id, rr);
  endtask
  task automatic wait_start(input int r, output int s);
    int c0, lim;
    c0 = cyc;
    lim = cyc + 40;
    s = -1;
    while (s < 0 && cyc < lim) begin
      drive();
      bus.tx_done = 1'b0;
      @(negedge clk);
      if (bus.tx_start) begin
        s = cyc;
        check("ws_gid", bus.grant_id, r);
        consume();
      end
      tick();
    end
    check("ws_latency", s, c0 + 1);
  endtask
  task automatic timeout_case(input int r, input logic [7:0] d, input bit give_done);
    int s, first_err;
    push_byte(r, 1'b1, d);
    wait_start(r, s);
    first_err = -1;
    while (cyc <= s + TO + 2) begin
      drive();
      bus.tx_done = give_done && (cyc == s + TO);
      @(negedge clk);
      if (bus.timeout_err && first_err < 0) first_err = cyc;
      tick();
    end
    bus.tx_done = 1'b0;
    check("to_err_cyc", first_err, give_done ? -1 : s + TO + 1);
    check("to_active", bus.grant_active, 0);
    rr = r;
    idle_wait(GAP + 4);
  endtask
  initial begin
    int s;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    for (int i = 0; i < N; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", bus.tx_start, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_data", bus.tx_data, 0);
    check("rst_gid", bus.grant_id, N - 1);
    check("rst_active", bus.grant_active, 0);
    check("rst_err", bus.timeout_err, 0);
    tick();
    rst = 1'b0;
    push_byte(0, 1'b0, 8'h48);
    push_byte(0, 1'b1, 8'h69);
    run_round();
    idle_wait(GAP + 6);
    push_byte(1, 1'b1, 8'h01);
    run_round();
    idle_wait(GAP + 6);
    push_byte(1, 1'b1, 8'hA1);
    push_byte(3, 1'b1, 8'hB3);
    run_round();
    idle_wait(GAP + 6);
    push_msg(2, 10);
    run_round();
    idle_wait(GAP + 6);
    timeout_case(1, 8'hD0, 1'b1);
    check("err_edge_clear", bus.timeout_err, 0);
    timeout_case(0, 8'h5A, 1'b0);
    push_byte(1, 1'b0, 8'h55);
    push_byte(0, 1'b1, 8'h77);
    push_byte(2, 1'b1, 8'h66);
    run_round();
    idle_wait(GAP + 6);
    check("err_sticky", bus.timeout_err, 1);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) != 0)
          for (int m = 0; m < int'($urandom_range(1, 3)); m++) push_msg(i, int'($urandom_range(1, 12)));
      run_round();
      idle_wait(GAP + 6);
    end
    push_byte(2, 1'b1, 8'hC3);
    wait_start(2, s);
    drive();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_start", bus.tx_start, 0);
    check("arst_ready", bus.req_ready, 0);
    check("arst_data", bus.tx_data, 0);
    check("arst_gid", bus.grant_id, N - 1);
    check("arst_active", bus.grant_active, 0);
    check("arst_err", bus.timeout_err, 0);
    tick();
    rst = 1'b0;
    rr = N - 1;
    push_byte(1, 1'b1, 8'h11);
    push_byte(0, 1'b1, 8'h22);
    run_round();
    idle_wait(GAP + 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
